// File: rtl/atan_pkg.sv
`default_nettype none
// ============================================================================
// Package     : atan_pkg
// Description : Shared constants and the pipeline tag type for atan_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package atan_pkg;

  // Advancing edges from CORDIC input to phase output.
  localparam int CORDIC_LAT = 19;

  // Channel-id width carried in each tag.
  localparam int TAG_CHW = 2;

  // One slot of the tag line that shadows the CORDIC pipeline.
  typedef struct packed {
    logic               v;
    logic [TAG_CHW-1:0] ch;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Show-ahead synchronous FIFO with occupancy count and flush.
//               A push into a full FIFO is accepted when a pop happens on
//               the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 18
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  // Pointer increment with wrap for non power-of-two depths.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop_i && (r_count != '0);
  assign w_do_push = push_i && (!w_full || w_do_pop);

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr] <= din_i;
    end
  end

  // Pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (clr_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= ptr_inc(r_wr);
      end
      if (w_do_pop) begin
        r_rd <= ptr_inc(r_rd);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout_o  = r_mem[r_rd];
  assign valid_o = (r_count != '0);
  assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/atan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : atan_scheduler
// Description : Round-robin sharing of one arcTan CORDIC pipeline between NCH
//               requesters. Samples carry a channel tag through a shadow tag
//               line; phases return through a credit-limited result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module atan_scheduler
  import atan_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int CHW    = 2,
  parameter int IW     = 16,
  parameter int LAT    = CORDIC_LAT,
  parameter int FDEPTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic [NCH-1:0]    req_valid_i,
  output logic [NCH-1:0]    req_ready_o,
  input  logic [NCH*IW-1:0] req_cos_i,
  input  logic [NCH*IW-1:0] req_sin_i,
  output logic              cor_valid_o,
  output logic [IW-1:0]     cor_cos_o,
  output logic [IW-1:0]     cor_sin_o,
  input  logic [IW-1:0]     cor_phase_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [CHW-1:0]    res_ch_o,
  output logic [IW-1:0]     res_phase_o,
  output logic              busy_o
);

  localparam int CW = $clog2(FDEPTH) + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         r_state;
  logic [CHW-1:0] r_rr_ptr;
  logic [CW-1:0]  r_inflight;
  tag_t           r_tag [LAT];

  logic [CW-1:0]       w_fifo_count;
  logic [CW:0]         w_used;
  logic                w_can_issue;
  logic                w_hs;
  logic [CHW-1:0]      w_gnt_ch;
  logic [NCH-1:0]      w_ready;
  tag_t                w_tag_in;
  logic                w_cap;
  logic [CW-1:0]       w_inflight_nxt;
  logic                w_fifo_valid;
  logic [CHW+IW-1:0]   w_fifo_dout;
  logic                w_pop;

  // Channel index offset from the round-robin pointer, modulo NCH.
  function automatic logic [CHW-1:0] rr_idx(input logic [CHW-1:0] p, input int off);
    int s;
    s = (int'(p) + off) % NCH;
    return CHW'(s);
  endfunction

  // Every sample in the pipeline or the FIFO holds one credit; async reset
  // also blocks grants so all request-side outputs read zero while it is held.
  assign w_used      = {1'b0, r_inflight} + {1'b0, w_fifo_count};
  assign w_can_issue = !rst_i && !clr_i && (w_used < (CW+1)'(FDEPTH));

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_hs     = 1'b0;
    w_gnt_ch = '0;
    w_ready  = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!w_hs && w_can_issue && req_valid_i[rr_idx(r_rr_ptr, i)]) begin
        w_hs     = 1'b1;
        w_gnt_ch = rr_idx(r_rr_ptr, i);
      end
    end
    if (w_hs) begin
      w_ready[w_gnt_ch] = 1'b1;
    end
  end

  assign req_ready_o = w_ready;

  // Forward the granted sample, or a zero bubble, and build its tag.
  always_comb begin
    cor_cos_o   = '0;
    cor_sin_o   = '0;
    w_tag_in    = '0;
    if (w_hs) begin
      cor_cos_o   = req_cos_i[w_gnt_ch*IW +: IW];
      cor_sin_o   = req_sin_i[w_gnt_ch*IW +: IW];
      w_tag_in.v  = 1'b1;
      w_tag_in.ch = w_gnt_ch;
    end
  end

  // Combinational so the first issue out of IDLE enters the CORDIC at once.
  assign cor_valid_o = (r_state == S_RUN) || w_hs;

  assign w_cap = r_tag[LAT-1].v && cor_valid_o;

  // Next in-flight count: handshake adds, capture retires.
  always_comb begin
    case ({w_hs, w_cap})
      2'b10:   w_inflight_nxt = r_inflight + 1'b1;
      2'b01:   w_inflight_nxt = r_inflight - 1'b1;
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  // Tag line moves in lock-step with the CORDIC, which only advances on valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else if (clr_i) begin
      for (int k = 0; k < LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else if (cor_valid_o) begin
      r_tag[0] <= w_tag_in;
      for (int k = 1; k < LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // In-flight counter; abort discards all outstanding work.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= '0;
    end else if (clr_i) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
    end
  end

  // Round-robin pointer remembers the last granted channel across aborts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= CHW'(NCH - 1);
    end else if (w_hs) begin
      r_rr_ptr <= w_gnt_ch;
    end
  end

  // Control FSM: RUN keeps bubbles flowing until the last tagged sample exits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else if (clr_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_hs) r_state <= S_RUN;
        S_RUN:   if (!w_hs && (w_inflight_nxt == '0)) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (r_state == S_RUN);

  assign w_pop = w_fifo_valid && res_ready_i;

  sync_fifo #(
    .DEPTH (FDEPTH),
    .W     (CHW + IW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .push_i  (w_cap),
    .din_i   ({r_tag[LAT-1].ch, cor_phase_i}),
    .pop_i   (w_pop),
    .dout_o  (w_fifo_dout),
    .valid_o (w_fifo_valid),
    .count_o (w_fifo_count)
  );

  assign res_valid_o = w_fifo_valid;
  assign res_ch_o    = w_fifo_dout[IW +: CHW];
  assign res_phase_o = w_fifo_dout[IW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_atan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_atan_scheduler
// Description : Self-checking bench for atan_scheduler with a behavioural
//               arcTan pipeline and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atan_scheduler;

  localparam int NCH    = 4;
  localparam int CHW    = 2;
  localparam int IW     = 16;
  localparam int LAT    = 19;
  localparam int FDEPTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic [NCH-1:0]    req_valid = '0;
  logic [NCH-1:0]    req_ready;
  logic [NCH*IW-1:0] req_cos = '0;
  logic [NCH*IW-1:0] req_sin = '0;
  logic              cor_valid;
  logic [IW-1:0]     cor_cos;
  logic [IW-1:0]     cor_sin;
  logic [IW-1:0]     cor_phase;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [CHW-1:0]    res_ch;
  logic [IW-1:0]     res_phase;
  logic              busy;
  logic              rst_n;

  int n_pass  = 0;
  int n_total = 0;
  int exp_rr  = NCH - 1;

  logic [17:0] sb [$];
  logic [17:0] mon_e;
  logic [15:0] m_pipe [LAT];

  logic [15:0] ch_cos [NCH] = '{16'h4000, 16'h0000, 16'hC000, 16'h2D41};
  logic [15:0] ch_sin [NCH] = '{16'h0000, 16'h4000, 16'h0001, 16'hD2BF};

  always #5 clk = ~clk;

  assign rst_n = ~rst;

  atan_scheduler #(
    .NCH(NCH), .CHW(CHW), .IW(IW), .LAT(LAT), .FDEPTH(FDEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (clr),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_cos_i   (req_cos),
    .req_sin_i   (req_sin),
    .cor_valid_o (cor_valid),
    .cor_cos_o   (cor_cos),
    .cor_sin_o   (cor_sin),
    .cor_phase_i (cor_phase),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_ch_o    (res_ch),
    .res_phase_o (res_phase),
    .busy_o      (busy)
  );

  // Reference angle of (cos, sin) in unsigned Q3.13 radians, range [0, 2pi).
  function automatic logic [15:0] ref_phase(input logic [15:0] c, input logic [15:0] s);
    real a;
    int  q;
    a = $atan2(real'($signed(s)), real'($signed(c)));
    if (a < 0.0) a = a + 2.0 * 3.14159265358979;
    q = int'(a * 8192.0);
    return q[15:0];
  endfunction

  // Behavioural arcTan: LAT-deep pipeline that advances only on valid.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) m_pipe[k] <= '0;
    end else if (cor_valid) begin
      m_pipe[0] <= ref_phase(cor_cos, cor_sin);
      for (int k = 1; k < LAT; k++) m_pipe[k] <= m_pipe[k-1];
    end
  end
  assign cor_phase = m_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_tol(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    int  d;
    logic ok;
    d  = int'(obs) - int'(exp);
    ok = (d <= 4) && (d >= -4);
    n_total++;
    assert (ok === 1'b1) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (+/-4)", tag, obs, exp);
  endtask

  function automatic logic [3:0] onehot(input int c);
    logic [3:0] v;
    v = '0;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  // Bench-side round-robin expectation.
  function automatic int next_rr(input logic [3:0] v);
    for (int i = 1; i <= NCH; i++) begin
      if (v[(exp_rr + i) % NCH]) return (exp_rr + i) % NCH;
    end
    return -1;
  endfunction

  task automatic set_lane(input int c, input logic [15:0] cs, input logic [15:0] sn);
    req_cos[c*IW +: IW] = cs;
    req_sin[c*IW +: IW] = sn;
  endtask

  task automatic load_lanes();
    for (int c = 0; c < NCH; c++) set_lane(c, ch_cos[c], ch_sin[c]);
  endtask

  // Result monitor: every pop is matched against the scoreboard head.
  always begin
    @(negedge clk);
    #2;
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("res_ch", 32'(res_ch), 32'(mon_e[17:16]));
        chk_tol("res_phase", res_phase, mon_e[15:0]);
      end
    end
  end

  // Called just after a negedge with req_valid already all ones.
  task automatic run_stream(input int n);
    int nx;
    repeat (n) begin
      #1;
      nx = next_rr(req_valid);
      chk("stream_grant", 32'(req_ready), 32'(onehot(nx)));
      sb.push_back({nx[1:0], ref_phase(ch_cos[nx], ch_sin[nx])});
      exp_rr = nx;
      @(negedge clk);
    end
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Single request from channel c; checks grant, latency, channel and phase.
  task automatic single(input string tag, input int c, input logic [15:0] cs,
                        input logic [15:0] sn, input logic [15:0] pconst);
    int cnt;
    req_valid = onehot(c);
    set_lane(c, cs, sn);
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(onehot(c)));
    chk({tag, "_corv"}, 32'(cor_valid), 32'd1);
    sb.push_back({c[1:0], ref_phase(cs, sn)});
    exp_rr = c;
    @(negedge clk);
    req_valid = '0;
    #1;
    cnt = 1;
    while (!res_valid && cnt < 40) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(LAT + 1));
    chk({tag, "_ch"}, 32'(res_ch), 32'(c));
    chk_tol({tag, "_phase"}, res_phase, pconst);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int seen;

    // Reset state, with requests present to show grants are suppressed.
    req_valid = 4'hF;
    load_lanes();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_corv", 32'(cor_valid), 32'd0);
    chk("rst_resv", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);

    // 1: single quarter-turn sample on channel 1.
    single("t1", 1, 16'h0000, 16'h4000, 16'h3244);

    // 2: all channels streaming, results in issue order.
    load_lanes();
    req_valid = 4'hF;
    run_stream(12);
    req_valid = '0;
    drain(60);
    chk("t2_busy", 32'(busy), 32'd0);

    // 3: lone sample from ch3 keeps the pipe primed with bubbles.
    @(negedge clk);
    req_valid = 4'b1000;
    set_lane(3, 16'hC000, 16'h0001);
    #1;
    chk("t3_grant", 32'(req_ready), 32'(onehot(next_rr(4'b1000))));
    sb.push_back({2'd3, ref_phase(16'hC000, 16'h0001)});
    exp_rr = 3;
    cnt = 1;
    @(negedge clk);
    req_valid = '0;
    #1;
    while (cor_valid && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("t3_bubbles", 32'(cnt), 32'(LAT + 1));
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_resv", 32'(res_valid), 32'd1);
    chk("t3_ch", 32'(res_ch), 32'd3);
    chk_tol("t3_phase", res_phase, 16'h6488);
    @(negedge clk);

    // 4: stalled consumer exhausts credits after exactly FDEPTH grants.
    load_lanes();
    res_ready = 1'b0;
    req_valid = 4'hF;
    run_stream(FDEPTH);
    for (int i = 0; i < 24; i++) begin
      #1;
      chk("t4_stall_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("t4_full_valid", 32'(res_valid), 32'd1);
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge clk);
    drain(80);
    single("t4_resume", 0, 16'h4000, 16'h0000, 16'h0000);

    // 5: abort three in-flight samples.
    req_valid = 4'b0001;
    set_lane(0, 16'h4000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_issue", 32'(req_ready), 32'b0001);
      @(negedge clk);
    end
    req_valid = '0;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("t5_clr_nogrant", 32'(req_ready), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    req_valid = '0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_corv", 32'(cor_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (res_valid) seen++;
    end
    chk("t5_noresult", 32'(seen), 32'd0);
    @(negedge clk);
    single("t5_after", 2, 16'h4000, 16'h0000, 16'h0000);

    // 6: asynchronous reset in the middle of a stream.
    load_lanes();
    req_valid = 4'hF;
    run_stream(8);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("t6_ready", 32'(req_ready), 32'd0);
    chk("t6_corv", 32'(cor_valid), 32'd0);
    chk("t6_resv", 32'(res_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    exp_rr = NCH - 1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    single("t6_after", 1, 16'h0000, 16'h4000, 16'h3244);

    drain(40);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
